// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage SRAM interface.
//   mem_state_e : access FSM states (idle, low halfword, high halfword, done)
//   SRAM_DW     : external SRAM data width
//   WORD_W      : pipeline word width
//   CNT_W       : width of the per-phase wait counter (covers 1..15 wait cycles)
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } mem_state_e;

  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/sram_phase_timer.sv
// Wait-state timer for one SRAM halfword phase.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : force the count back to zero
//   en_i          : a phase is in progress; count this cycle
//   phase_done_o  : high in the last cycle of a phase (count == WAIT_CYCLES-1)
// The count wraps to zero on phase_done_o so the next phase starts fresh.
module sram_phase_timer
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic phase_done_o
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign phase_done_o = en_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || phase_done_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: 32-bit loads/stores over a 16-bit asynchronous SRAM,
// done as a low halfword phase then a high halfword phase, each WAIT_CYCLES long.
// freeze stalls the pipeline while an access is in flight; ready pulses for one
// cycle when it completes and MEM_result then holds the full load word.
// Optional build macro MEM_ADDR_RANGE_CHECK_EN: out-of-window or misaligned
// addresses finish immediately with mem_err; otherwise addresses wrap.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN     : load / store request (both set -> load)
//   ALU_result             : byte address
//   ST_val                 : store data
//   MEM_result             : last completed load data
//   ready, freeze, mem_err : completion pulse, pipeline stall, range-error pulse
//   SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_I, SRAM_DQ_OE, SRAM_WE_N : SRAM interface
module mem_stage_sram
  import mem_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned       SRAM_AW     = 18,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [WORD_W-1:0]  ALU_result,
  input  logic [WORD_W-1:0]  ST_val,
  output logic [WORD_W-1:0]  MEM_result,
  output logic               ready,
  output logic               freeze,
  output logic               mem_err,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [SRAM_DW-1:0] SRAM_DQ_O,
  input  logic [SRAM_DW-1:0] SRAM_DQ_I,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N
);

  localparam int unsigned IdxW = SRAM_AW - 1;

  mem_state_e state_q, state_d;

  logic               req;
  logic               is_store_in;
  logic               addr_err;
  logic [IdxW-1:0]    idx_in;
  logic               phase_done;
  logic               store_q;
  logic               err_q;
  logic [SRAM_DW-1:0] st_hi_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [SRAM_DW-1:0] dq_o_q;
  logic [WORD_W-1:0]  mem_result_q;

  assign req         = MEM_R_EN | MEM_W_EN;
  assign is_store_in = MEM_W_EN & ~MEM_R_EN;
  // Word index within the SRAM; the subtraction wraps for addresses below BASE_ADDR.
  assign idx_in      = IdxW'((ALU_result - BASE_ADDR) >> 2);

`ifdef MEM_ADDR_RANGE_CHECK_EN
  localparam logic [WORD_W:0] AddrLimit =
    {1'b0, BASE_ADDR} + ((WORD_W + 1)'(1) << (SRAM_AW + 1));

  assign addr_err = (ALU_result < BASE_ADDR) || ({1'b0, ALU_result} >= AddrLimit) ||
                    (ALU_result[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == StIdle),
    .en_i         ((state_q == StLo) || (state_q == StHi)),
    .phase_done_o (phase_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req) state_d = addr_err ? StDone : StLo;
      StLo:    if (phase_done) state_d = StHi;
      StHi:    if (phase_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; WE_N is only ever low inside a phase
  always_comb begin
    freeze     = 1'b0;
    ready      = 1'b0;
    mem_err    = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    case (state_q)
      StIdle: freeze = req & ~rst;
      StLo, StHi: begin
        freeze     = 1'b1;
        SRAM_WE_N  = ~store_q;
        SRAM_DQ_OE = store_q;
      end
      StDone: begin
        ready   = 1'b1;
        mem_err = err_q;
      end
      default: ;
    endcase
  end

  // Access datapath: latched request, SRAM address/data and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      st_hi_q      <= '0;
      sram_addr_q  <= '0;
      dq_o_q       <= '0;
      mem_result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            store_q <= is_store_in;
            err_q   <= addr_err;
            if (!addr_err) begin
              sram_addr_q <= {idx_in, 1'b0};
              if (is_store_in) begin
                dq_o_q  <= ST_val[SRAM_DW-1:0];
                st_hi_q <= ST_val[WORD_W-1:SRAM_DW];
              end
            end else if (!is_store_in) begin
              mem_result_q <= '0;
            end
          end
        end
        StLo: begin
          if (phase_done) begin
            if (!store_q) mem_result_q[SRAM_DW-1:0] <= SRAM_DQ_I;
            else          dq_o_q <= st_hi_q;
            sram_addr_q[0] <= 1'b1;
          end
        end
        StHi: begin
          if (phase_done && !store_q) mem_result_q[WORD_W-1:SRAM_DW] <= SRAM_DQ_I;
        end
        default: ;
      endcase
    end
  end

  assign SRAM_ADDR  = sram_addr_q;
  assign SRAM_DQ_O  = dq_o_q;
  assign MEM_result = mem_result_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: dut_a runs with one wait cycle per phase, dut_b with
// three. Each has its own behavioural async SRAM (write on WE_N low at the clock).
module tb_mem_stage_sram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_r = 0, a_w = 0, b_r = 0, b_w = 0;
  logic [31:0] a_addr = 0, a_st = 0, b_addr = 0, b_st = 0;
  logic [31:0] a_res, b_res;
  logic        a_ready, a_freeze, a_err, a_oe, a_we_n;
  logic        b_ready, b_freeze, b_err, b_oe, b_we_n;
  logic [17:0] a_sa, b_sa;
  logic [15:0] a_dq_o, a_dq_i, b_dq_o, b_dq_i;

  logic [15:0] a_mem [262144];
  logic [15:0] b_mem [262144];

  logic        pl_en = 0, pl_b = 0;
  logic [17:0] pl_addr = 0;
  logic [15:0] pl_data = 0;

  mem_stage_sram #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .MEM_R_EN(a_r), .MEM_W_EN(a_w), .ALU_result(a_addr),
    .ST_val(a_st), .MEM_result(a_res), .ready(a_ready), .freeze(a_freeze),
    .mem_err(a_err), .SRAM_ADDR(a_sa), .SRAM_DQ_O(a_dq_o), .SRAM_DQ_I(a_dq_i),
    .SRAM_DQ_OE(a_oe), .SRAM_WE_N(a_we_n)
  );

  mem_stage_sram #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .MEM_R_EN(b_r), .MEM_W_EN(b_w), .ALU_result(b_addr),
    .ST_val(b_st), .MEM_result(b_res), .ready(b_ready), .freeze(b_freeze),
    .mem_err(b_err), .SRAM_ADDR(b_sa), .SRAM_DQ_O(b_dq_o), .SRAM_DQ_I(b_dq_i),
    .SRAM_DQ_OE(b_oe), .SRAM_WE_N(b_we_n)
  );

  assign a_dq_i = a_mem[a_sa];
  assign b_dq_i = b_mem[b_sa];

  always @(posedge clk) begin
    if (pl_en && !pl_b) a_mem[pl_addr] <= pl_data;
    else if (a_we_n === 1'b0) a_mem[a_sa] <= a_dq_o;
  end

  always @(posedge clk) begin
    if (pl_en && pl_b) b_mem[pl_addr] <= pl_data;
    else if (b_we_n === 1'b0) b_mem[b_sa] <= b_dq_o;
  end

  task automatic preload(input bit sel_b, input int unsigned addr, input logic [15:0] data);
    @(negedge clk);
    pl_b = sel_b; pl_addr = 18'(addr); pl_data = data; pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one request and watches it until ready (bounded); returns observations.
  task automatic access(input bit sel_b, input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, output int frz, output int rdy_at,
                        output int we_lo, output int oe_hi, output logic err_rdy,
                        output logic frz_rdy);
    frz = 0; rdy_at = -1; we_lo = 0; oe_hi = 0; err_rdy = 1'bx; frz_rdy = 1'bx;
    @(negedge clk);
    if (sel_b) begin b_r = r; b_w = w; b_addr = addr; b_st = data; end
    else begin a_r = r; a_w = w; a_addr = addr; a_st = data; end
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (sel_b ? b_freeze : a_freeze) frz++;
      if ((sel_b ? b_we_n : a_we_n) === 1'b0) we_lo++;
      if ((sel_b ? b_oe : a_oe) === 1'b1) oe_hi++;
      if ((sel_b ? b_ready : a_ready) === 1'b1) begin
        rdy_at = cyc;
        err_rdy = sel_b ? b_err : a_err;
        frz_rdy = sel_b ? b_freeze : a_freeze;
        break;
      end
      @(negedge clk);
    end
    if (sel_b) begin b_r = 0; b_w = 0; end
    else begin a_r = 0; a_w = 0; end
  endtask

  task automatic test_reset();
    a_r = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_freeze !== 1'b0) begin failures++; $display("FAIL rst_freeze: got %b want 0", a_freeze); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", a_ready); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", a_err); end
    checks++; if (a_we_n !== 1'b1) begin failures++; $display("FAIL rst_we_n: got %b want 1", a_we_n); end
    checks++; if (a_oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b want 0", a_oe); end
    checks++; if (a_sa !== 18'd0) begin failures++; $display("FAIL rst_addr: got %h want 0", a_sa); end
    checks++; if (a_dq_o !== 16'd0) begin failures++; $display("FAIL rst_dq_o: got %h want 0", a_dq_o); end
    checks++; if (a_res !== 32'd0) begin failures++; $display("FAIL rst_result: got %h want 0", a_res); end
    checks++; if (b_res !== 32'd0) begin failures++; $display("FAIL rst_result_b: got %h want 0", b_res); end
    a_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_freeze !== 1'b0 || a_ready !== 1'b0) begin
      failures++; $display("FAIL idle_hold: freeze=%b ready=%b want 0/0", a_freeze, a_ready);
    end
  endtask

  task automatic test_store();
    int frz, rdy, we, oe;
    logic err, fr;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, frz, rdy, we, oe, err, fr);
    checks++; if (frz != 3) begin failures++; $display("FAIL st_freeze_cycles: got %0d want 3", frz); end
    checks++; if (rdy != 3) begin failures++; $display("FAIL st_ready_cycle: got %0d want 3", rdy); end
    checks++; if (we != 2) begin failures++; $display("FAIL st_we_cycles: got %0d want 2", we); end
    checks++; if (oe != 2) begin failures++; $display("FAIL st_oe_cycles: got %0d want 2", oe); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL st_err: got %b want 0", err); end
    checks++; if (fr !== 1'b0) begin failures++; $display("FAIL st_freeze_at_ready: got %b want 0", fr); end
    @(negedge clk);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL st_ready_pulse: got %b want 0", a_ready); end
    checks++; if (a_mem[2] !== 16'hBEEF) begin failures++; $display("FAIL st_hw2: got %h want beef", a_mem[2]); end
    checks++; if (a_mem[3] !== 16'hDEAD) begin failures++; $display("FAIL st_hw3: got %h want dead", a_mem[3]); end
  endtask

  task automatic test_load();
    int frz, rdy, we, oe;
    logic err, fr;
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (a_res !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_data: got %h want deadbeef", a_res); end
    checks++; if (frz != 3) begin failures++; $display("FAIL ld_freeze_cycles: got %0d want 3", frz); end
    checks++; if (rdy != 3) begin failures++; $display("FAIL ld_ready_cycle: got %0d want 3", rdy); end
    checks++; if (oe != 0) begin failures++; $display("FAIL ld_oe_cycles: got %0d want 0", oe); end
    checks++; if (we != 0) begin failures++; $display("FAIL ld_we_cycles: got %0d want 0", we); end
    preload(1'b0, 10, 16'h1234);
    preload(1'b0, 11, 16'hABCD);
    access(1'b0, 1'b1, 1'b0, 32'd1044, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (a_res !== 32'hABCD1234) begin failures++; $display("FAIL ld_data2: got %h want abcd1234", a_res); end
  endtask

  task automatic test_both_en();
    int frz, rdy, we, oe;
    logic err, fr;
    access(1'b0, 1'b1, 1'b1, 32'd1028, 32'hFFFFFFFF, frz, rdy, we, oe, err, fr);
    checks++; if (we != 0) begin failures++; $display("FAIL both_we_cycles: got %0d want 0", we); end
    checks++; if (a_res !== 32'hDEADBEEF) begin failures++; $display("FAIL both_data: got %h want deadbeef", a_res); end
    checks++; if (a_mem[2] !== 16'hBEEF) begin failures++; $display("FAIL both_hw2: got %h want beef", a_mem[2]); end
    checks++; if (rdy != 3) begin failures++; $display("FAIL both_ready_cycle: got %0d want 3", rdy); end
  endtask

  task automatic test_range();
    int frz, rdy, we, oe;
    logic err, fr;
`ifdef MEM_ADDR_RANGE_CHECK_EN
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, frz, rdy, we, oe, err, fr);
    access(1'b0, 1'b1, 1'b0, 32'd1022, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (frz != 1) begin failures++; $display("FAIL rng_freeze_cycles: got %0d want 1", frz); end
    checks++; if (rdy != 1) begin failures++; $display("FAIL rng_ready_cycle: got %0d want 1", rdy); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL rng_err: got %b want 1", err); end
    checks++; if (a_res !== 32'd0) begin failures++; $display("FAIL rng_result: got %h want 0", a_res); end
    checks++; if (we != 0 || oe != 0) begin
      failures++; $display("FAIL rng_no_sram: we=%0d oe=%0d want 0/0", we, oe);
    end
    access(1'b0, 1'b0, 1'b1, 32'd1030, 32'h12345678, frz, rdy, we, oe, err, fr);
    checks++; if (err !== 1'b1 || we != 0) begin
      failures++; $display("FAIL rng_misaligned: err=%b we=%0d want 1/0", err, we);
    end
    checks++; if (a_mem[2] !== 16'hBEEF) begin failures++; $display("FAIL rng_hw2: got %h want beef", a_mem[2]); end
    access(1'b0, 1'b1, 1'b0, 32'd525312, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL rng_top: got %b want 1", err); end
    preload(1'b0, 262142, 16'h7777);
    preload(1'b0, 262143, 16'h8888);
    access(1'b0, 1'b1, 1'b0, 32'd525308, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (err !== 1'b0 || frz != 3) begin
      failures++; $display("FAIL rng_last_word: err=%b freeze=%0d want 0/3", err, frz);
    end
    checks++; if (a_res !== 32'h88887777) begin failures++; $display("FAIL rng_last_data: got %h want 88887777", a_res); end
`else
    preload(1'b0, 262142, 16'h7777);
    preload(1'b0, 262143, 16'h8888);
    access(1'b0, 1'b1, 1'b0, 32'd1022, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (a_res !== 32'h88887777) begin failures++; $display("FAIL wrap_data: got %h want 88887777", a_res); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_err: got %b want 0", err); end
    checks++; if (frz != 3) begin failures++; $display("FAIL wrap_freeze_cycles: got %0d want 3", frz); end
`endif
  endtask

  task automatic test_back_to_back();
    int frz, rdy, we, oe;
    logic err, fr;
    access(1'b1, 1'b0, 1'b1, 32'd1032, 32'h01234567, frz, rdy, we, oe, err, fr);
    checks++; if (frz != 7) begin failures++; $display("FAIL b2b_st_freeze: got %0d want 7", frz); end
    checks++; if (rdy != 7) begin failures++; $display("FAIL b2b_st_ready: got %0d want 7", rdy); end
    checks++; if (we != 6) begin failures++; $display("FAIL b2b_st_we: got %0d want 6", we); end
    access(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (frz != 7) begin failures++; $display("FAIL b2b_ld_freeze: got %0d want 7", frz); end
    checks++; if (rdy != 7) begin failures++; $display("FAIL b2b_ld_ready: got %0d want 7", rdy); end
    checks++; if (b_res !== 32'h01234567) begin failures++; $display("FAIL b2b_ld_data: got %h want 01234567", b_res); end
    checks++; if (b_mem[4] !== 16'h4567 || b_mem[5] !== 16'h0123) begin
      failures++; $display("FAIL b2b_mem: got %h_%h want 0123_4567", b_mem[5], b_mem[4]);
    end
  endtask

  task automatic test_reset_mid();
    int frz, rdy, we, oe;
    logic err, fr;
    preload(1'b1, 0, 16'h1111);
    preload(1'b1, 1, 16'h2222);
    @(negedge clk);
    b_w = 1'b1; b_addr = 32'd1024; b_st = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    checks++; if (b_we_n !== 1'b0) begin failures++; $display("FAIL mid_started: got we_n=%b want 0", b_we_n); end
    rst = 1'b1;
    #1;
    checks++; if (b_we_n !== 1'b1) begin failures++; $display("FAIL mid_we_n: got %b want 1", b_we_n); end
    checks++; if (b_freeze !== 1'b0) begin failures++; $display("FAIL mid_freeze: got %b want 0", b_freeze); end
    checks++; if (b_oe !== 1'b0) begin failures++; $display("FAIL mid_oe: got %b want 0", b_oe); end
    @(negedge clk);
    b_w = 1'b0;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (b_freeze !== 1'b0 || b_ready !== 1'b0) begin
      failures++; $display("FAIL mid_idle: freeze=%b ready=%b want 0/0", b_freeze, b_ready);
    end
    checks++; if (b_mem[1] !== 16'h2222) begin failures++; $display("FAIL mid_hw1: got %h want 2222", b_mem[1]); end
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, frz, rdy, we, oe, err, fr);
    checks++; if (frz != 7 || rdy != 7) begin
      failures++; $display("FAIL mid_restart: freeze=%0d ready=%0d want 7/7", frz, rdy);
    end
    checks++; if (b_res[31:16] !== 16'h2222) begin failures++; $display("FAIL mid_ld_hi: got %h want 2222", b_res[31:16]); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_both_en();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- MEM pipeline stage; directly downstream of the EXE stage, fed via the EXE/MEM register.
- Performs load/store of 32-bit words over an external 16-bit asynchronous SRAM, as two halfword phases with programmable wait states.
- Asserts freeze to stall the whole pipeline while an access is in flight; returns load data to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 1: cycles per halfword phase; legal range 1..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- ALU_result  in  32  byte address from EXE.
- ST_val  in  32  store data (Val_Rm).
- MEM_result  out  32  load data; holds the last completed load.
- ready  out  1  one-cycle pulse when an access completes.
- freeze  out  1  pipeline stall.
- mem_err  out  1  range-error pulse; tied to 0 without the optional feature.
- SRAM_ADDR  out  SRAM_AW  halfword address.
- SRAM_DQ_O  out  16  write data.
- SRAM_DQ_I  in  16  read data.
- SRAM_DQ_OE  out  1  data bus drive enable.
- SRAM_WE_N  out  1  write strobe, active low.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, counter=0, MEM_result=0.
  - ready=0, mem_err=0, SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_O=0.
  - freeze is forced 0 while rst=1.
  - Reset mid-access aborts the access; partial SRAM writes are not undone.
- Address and request decode:
  - idx = (ALU_result - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. Low phase uses halfword address {idx,0}; high phase uses {idx,1}.
  - req = MEM_R_EN | MEM_W_EN. If both are set, the access is treated as a load.
- FSM states: IDLE, LO, HI, DONE. One counter cnt (4 bits).
- IDLE:
  - freeze = req, combinational.
  - On req: latch address, store data and op; cnt=0; go to LO.
- LO:
  - SRAM_ADDR={idx,0}.
  - Store: SRAM_DQ_O=ST_val[15:0], SRAM_DQ_OE=1, SRAM_WE_N=0.
  - freeze=1; cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1: a load captures SRAM_DQ_I into MEM_result[15:0] on that edge; cnt=0; go to HI.
- HI: same as LO, using {idx,1}, ST_val[31:16] and MEM_result[31:16]; then go to DONE.
- DONE:
  - freeze=0, ready=1; SRAM_WE_N=1, SRAM_DQ_OE=0.
  - The pipeline advances this cycle; next state is IDLE.
- Timing:
  - freeze is high for exactly 1+2*WAIT_CYCLES cycles per access; ready fires in the following cycle.
  - SRAM_WE_N is never low in IDLE or DONE, so no strobe straddles a phase change.
- MEM_result low half updates before the high half; it is valid as a whole only from the ready cycle onward.
- A request that appears in the cycle after DONE starts normally from IDLE (back-to-back accesses allowed).
- Inputs are stable during freeze by contract; the latched copies are used regardless.
- No request: the FSM stays in IDLE and all outputs hold.

Optional Feature:
- Macro: MEM_ADDR_RANGE_CHECK_EN.
- Defined: an access is out of range if ALU_result < BASE_ADDR, ALU_result >= BASE_ADDR + 2^(SRAM_AW+1), or ALU_result[1:0] != 0. Such an access:
  - goes IDLE->DONE directly with no SRAM activity (SRAM_WE_N stays 1);
  - has freeze high for 1 cycle;
  - raises mem_err together with ready;
  - sets MEM_result to 0 for a load.
- Undefined: no check is made, addresses wrap modulo SRAM size, and mem_err is constant 0.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, LO, HI, DONE};
  - SRAM_DW=16, WORD_W=32;
  - width constant for the wait counter.
- Sub-module sram_phase_timer: loadable WAIT_CYCLES counter that outputs phase_done. The FSM and datapath stay in the top module.

Test Plan:
- Store 0xDEADBEEF to 1028, W=1 -> halfword 2 written 0xBEEF, halfword 3 written 0xDEAD; freeze high 3 cycles; ready pulses in cycle 4.
- Load from 1028 after the store -> MEM_result=0xDEADBEEF at ready; SRAM_DQ_OE stays 0 throughout.
- Back-to-back store then load, WAIT_CYCLES=3 -> each access has 7 freeze cycles, one idle/ready cycle between them, correct data.
- rst asserted mid-LO of a store -> SRAM_WE_N=1, freeze=0, state IDLE immediately; halfword 1 write is never started.
- Both MEM_R_EN and MEM_W_EN=1 -> load performed; SRAM_WE_N never low.
- With MEM_ADDR_RANGE_CHECK_EN, load from 1022 -> freeze 1 cycle, ready and mem_err pulse together, MEM_result=0, no SRAM strobe.
